detector_jogada: RTL and testbench
==================================

Name: detector_jogada

Overview:
- Upstream input stage of the game datapath: conditions the raw player buttons and feeds the control unit's `jogada` input.
- The raw buttons are asynchronous and bouncy.
- Outputs per accepted press:
  - one clean single-cycle `jogada` pulse;
  - the registered one-hot button code, which the datapath compares against the memory contents.
- Ignores held buttons, bounces and ambiguous multi-button presses.

Parameters:
- N_BOTOES, 4, number of player buttons; width of the button code.
- DEBOUNCE_CICLOS, 4, consecutive stable cycles required to accept a press or a release. Legal range 1..65535.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; reset=0 at a rising clock edge clears the block.
- botoes  input  N_BOTOES  raw asynchronous button levels, 1 = pressed.
- jogada  output  1  single-cycle pulse per accepted press.
- botoes_reg  output  N_BOTOES  one-hot code of the last accepted press; held until the next accepted press.
- db_estado  output  4  current FSM state code, for debug.

Behaviour:
- Synchronizer: `botoes` passes through a 2-flop synchronizer to give `botoes_s`. The FSM only ever uses `botoes_s`.
- Reset (reset=0 at an edge):
  - FSM goes to OCIOSO.
  - Synchronizer flops, filter counter and candidate register clear to 0.
  - `botoes_reg`=0, `jogada`=0.
  - Reset overrides any state, including mid-filter and mid-pulse. No pulse is emitted afterwards for a press already in progress unless that press is re-filtered from OCIOSO.
- Moore FSM, state codes given in parentheses.
- OCIOSO (0):
  - Exactly one bit of `botoes_s` set: load candidate = `botoes_s`, clear counter, go to FILTRANDO.
  - Zero bits set: stay.
  - Two or more bits set: stay (see optional feature).
- FILTRANDO (1):
  - `botoes_s` != candidate: go to OCIOSO. This covers bounce, release, or a second button joining.
  - Otherwise the counter increments. After DEBOUNCE_CICLOS consecutive matching cycles in FILTRANDO, go to PULSO.
- PULSO (2):
  - `jogada`=1 for exactly this one cycle.
  - `botoes_reg` is loaded with the candidate on the edge entering PULSO, so it is valid in the same cycle as `jogada`.
  - Unconditionally go to ESPERA_SOLTAR; clear the counter.
- ESPERA_SOLTAR (3):
  - `botoes_s`==0: increment the counter.
  - Any bit set: clear the counter.
  - After DEBOUNCE_CICLOS consecutive zero cycles, go to OCIOSO.
  - A held button therefore never produces a second pulse.
- Unused codes: next state OCIOSO; `db_estado`=4'hF.
- Latency: with the input stable from sampling edge e0, `jogada` is high in the cycle after edge e0+2+DEBOUNCE_CICLOS.
- Minimum spacing between two pulses: 2·DEBOUNCE_CICLOS+2 cycles.
- Counter:
  - Width is $clog2(DEBOUNCE_CICLOS+1).
  - Compares against DEBOUNCE_CICLOS-1 and never wraps.
- `jogada` is asserted regardless of the control unit's state. Ignoring pulses outside its wait state is the consumer's job.

Optional Feature:
- Macro: DETECTOR_JOGADA_MULTIPLO_EN.
- When defined:
  - Adds output `erro_multiplo` (1 bit).
  - Adds state MULTIPLO (code 4'h4), entered from OCIOSO when two or more bits of `botoes_s` are set.
  - In MULTIPLO, `erro_multiplo`=1, `jogada`=0 and `botoes_reg` is unchanged.
  - MULTIPLO exits to ESPERA_SOLTAR when `botoes_s`==0.
  - `erro_multiplo` resets to 0.
- When undefined: no port, no state; multi-presses are silently ignored while in OCIOSO.

Decomposition:
- Shared package `jogo_pkg` holds:
  - 4-bit state encodings (OCIOSO=0, FILTRANDO=1, PULSO=2, ESPERA_SOLTAR=3, MULTIPLO=4, invalid=F);
  - the one-hot validity function (exactly one bit set), reused by the datapath.
- One sub-module: `sincronizador_2ff`, parameterized width, synchronous active-low reset.

Test Plan (all with DEBOUNCE_CICLOS=4):
- Reset with `botoes`=0010 held: after reset is released, `botoes_reg` stays 0000 until the press is re-filtered; `jogada` then pulses exactly once.
- Clean press: `botoes`=0100 held from edge e0 gives `jogada`=1 in the cycle after e0+6 only, with `botoes_reg`=0100 in that same cycle. Holding for 100 cycles gives no further pulse.
- Bounce: `botoes` toggles 0001/0000 every 2 cycles for 20 cycles, then holds 0001. No pulse during bouncing; exactly one pulse 6 cycles after the final stable sample.
- Multi-press: `botoes`=0011 held 20 cycles gives no pulse and `botoes_reg` unchanged. With the macro defined, `erro_multiplo`=1 starting 3 cycles after the first sampling edge.
- Release bounce: after an accepted press of 1000, release with 3-cycle glitches back to 1000. No second pulse; the next press of 0001 after 4 quiet cycles pulses with `botoes_reg`=0001.
- Mid-filter reset: press 0010, then reset=0 at the 3rd FILTRANDO cycle. Then `db_estado`=0, no pulse; the press must re-filter for the full 4 cycles.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the game datapath: FSM state codes and button-code helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   estado_t           4-bit state encoding shared by detector_jogada and its debug port
//   MAX_BOTOES         widest button code the helper functions accept
//   um_bit_ativo()     1 when exactly one bit of the code is set (valid one-hot press)
//   varios_bits_ativos 1 when two or more bits are set (ambiguous multi-button press)
package jogo_pkg;

  typedef enum logic [3:0] {
    OCIOSO        = 4'h0,
    FILTRANDO     = 4'h1,
    PULSO         = 4'h2,
    ESPERA_SOLTAR = 4'h3,
    MULTIPLO      = 4'h4,
    INVALIDO      = 4'hF
  } estado_t;

  localparam int unsigned MAX_BOTOES = 32;

  localparam logic [MAX_BOTOES-1:0] UM_BOTAO = {{(MAX_BOTOES-1){1'b0}}, 1'b1};

  // v & (v-1) clears the lowest set bit; a zero result means at most one bit was set.
  function automatic logic um_bit_ativo(input logic [MAX_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - UM_BOTAO)) == '0);
  endfunction

  function automatic logic varios_bits_ativos(input logic [MAX_BOTOES-1:0] v);
    return (v & (v - UM_BOTAO)) != '0;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer bringing asynchronous levels into the clock domain.
// Latency: 2 cycles from sampling edge to output.
// Backpressure: none; free-running, samples every cycle.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-low clear of both stages
//   d      asynchronous input levels (LARGURA bits)
//   q      synchronized levels (LARGURA bits)
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta_q;
  logic [LARGURA-1:0] sinc_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d;
      sinc_q <= meta_q;
    end
  end

  assign q = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Player button conditioner: synchronizes, debounces and turns each accepted press into one pulse.
// Latency: jogada high in the cycle after edge e0+2+DEBOUNCE_CICLOS for an input stable from edge e0.
// Backpressure: none; jogada fires regardless of the consumer, who must ignore unwanted pulses.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-low reset
//   botoes         raw asynchronous button levels, 1 = pressed (N_BOTOES bits)
//   jogada         single-cycle pulse per accepted press
//   botoes_reg     one-hot code of the last accepted press, held until the next one
//   erro_multiplo  only with DETECTOR_JOGADA_MULTIPLO_EN: high while a multi-button press is held
//   db_estado      current state code, 4'hF for unused codes
//
// Optional feature macro: DETECTOR_JOGADA_MULTIPLO_EN adds the MULTIPLO state and erro_multiplo.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada,
  output logic [N_BOTOES-1:0] botoes_reg,
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
  output logic                erro_multiplo,
`endif
  output logic [3:0]          db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
  // The counter stops at DEBOUNCE_CICLOS-1, so it never needs to wrap.
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

  logic [N_BOTOES-1:0] botoes_s;

  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] botoes_reg_q, botoes_reg_d;
  logic                jogada_q, jogada_d;
  logic                um_bit;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
  logic                erro_q, erro_d;
  logic                varios_bits;
`endif

  sincronizador_2ff #(
    .LARGURA (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (botoes_s)
  );

  assign um_bit = um_bit_ativo(MAX_BOTOES'(botoes_s));
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
  assign varios_bits = varios_bits_ativos(MAX_BOTOES'(botoes_s));
`endif

  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    botoes_reg_d = botoes_reg_q;

    case (estado_q)
      OCIOSO: begin
        cnt_d = '0;
        if (um_bit) begin
          cand_d   = botoes_s;
          estado_d = FILTRANDO;
        end
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
        else if (varios_bits) begin
          estado_d = MULTIPLO;
        end
`endif
      end

      FILTRANDO: begin
        // Any change (bounce, release, a second button joining) restarts from idle.
        if (botoes_s != cand_q) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d     = PULSO;
          cnt_d        = '0;
          // Loaded on the edge entering PULSO so the code is valid alongside jogada.
          botoes_reg_d = cand_q;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end

      PULSO: begin
        estado_d = ESPERA_SOLTAR;
        cnt_d    = '0;
      end

      ESPERA_SOLTAR: begin
        // Only DEBOUNCE_CICLOS consecutive all-released cycles re-arm the detector.
        if (botoes_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end

`ifdef DETECTOR_JOGADA_MULTIPLO_EN
      MULTIPLO: begin
        cnt_d = '0;
        // Released buttons still go through the release filter before re-arming.
        if (botoes_s == '0) begin
          estado_d = ESPERA_SOLTAR;
        end
      end
`endif

      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    jogada_d = (estado_d == PULSO);
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
    erro_d   = (estado_d == MULTIPLO);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      cnt_q        <= '0;
      cand_q       <= '0;
      botoes_reg_q <= '0;
      jogada_q     <= 1'b0;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
      erro_q       <= 1'b0;
`endif
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      botoes_reg_q <= botoes_reg_d;
      jogada_q     <= jogada_d;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
      erro_q       <= erro_d;
`endif
    end
  end

  always_comb begin
    case (estado_q)
      OCIOSO, FILTRANDO, PULSO, ESPERA_SOLTAR: db_estado = estado_q;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
      MULTIPLO:                                db_estado = estado_q;
`endif
      default:                                 db_estado = INVALIDO;
    endcase
  end

  assign jogada     = jogada_q;
  assign botoes_reg = botoes_reg_q;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
  assign erro_multiplo = erro_q;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada with DEBOUNCE_CICLOS=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       jogada;
  logic [3:0] botoes_reg;
  logic [3:0] db_estado;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
  logic       erro_multiplo;
  localparam logic [3:0] EST_MULTI = 4'h4;
`else
  localparam logic [3:0] EST_MULTI = 4'h0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  detector_jogada #(
    .N_BOTOES        (4),
    .DEBOUNCE_CICLOS (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes        (botoes),
    .jogada        (jogada),
    .botoes_reg    (botoes_reg),
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
    .erro_multiplo (erro_multiplo),
`endif
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] b;
    logic       jog;
    logic [3:0] breg;
    logic [3:0] est;
  } vec_t;

  vec_t tabela [15];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
    else
      n_pass++;
  endtask

  // Holds b for n edges and counts the jogada pulses observed.
  task automatic rodar(input logic [3:0] b, input int n, output int pulsos);
    pulsos = 0;
    botoes = b;
    for (int i = 0; i < n; i++) begin
      step();
      if (jogada) pulsos++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p, p1, p2, jm;

    // Clean press of 0100 from idle, then release; one row per edge.
    tabela[0]  = '{4'b0100, 1'b0, 4'b0000, 4'h0};
    tabela[1]  = '{4'b0100, 1'b0, 4'b0000, 4'h0};
    tabela[2]  = '{4'b0100, 1'b0, 4'b0000, 4'h1};
    tabela[3]  = '{4'b0100, 1'b0, 4'b0000, 4'h1};
    tabela[4]  = '{4'b0100, 1'b0, 4'b0000, 4'h1};
    tabela[5]  = '{4'b0100, 1'b0, 4'b0000, 4'h1};
    tabela[6]  = '{4'b0100, 1'b1, 4'b0100, 4'h2};
    tabela[7]  = '{4'b0100, 1'b0, 4'b0100, 4'h3};
    tabela[8]  = '{4'b0100, 1'b0, 4'b0100, 4'h3};
    tabela[9]  = '{4'b0000, 1'b0, 4'b0100, 4'h3};
    tabela[10] = '{4'b0000, 1'b0, 4'b0100, 4'h3};
    tabela[11] = '{4'b0000, 1'b0, 4'b0100, 4'h3};
    tabela[12] = '{4'b0000, 1'b0, 4'b0100, 4'h3};
    tabela[13] = '{4'b0000, 1'b0, 4'b0100, 4'h3};
    tabela[14] = '{4'b0000, 1'b0, 4'b0100, 4'h0};

    // Reset with 0010 held: nothing until the press is re-filtered after reset.
    reset  = 1'b0;
    botoes = 4'b0010;
    step(); step(); step();
    chk("reset_jogada", jogada, 1'b0);
    chk("reset_botoes_reg", botoes_reg, 4'b0000);
    chk("reset_estado", db_estado, 4'h0);
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
    chk("reset_erro", erro_multiplo, 1'b0);
`endif
    reset = 1'b1;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (jogada) p++;
      if (botoes_reg != 4'b0000) p += 100;
    end
    chk("reset_refiltro_sem_pulso", p, 0);
    step();
    chk("reset_refiltro_jogada", jogada, 1'b1);
    chk("reset_refiltro_reg", botoes_reg, 4'b0010);
    rodar(4'b0010, 10, p);
    chk("reset_hold_sem_pulso", p, 0);
    rodar(4'b0000, 10, p);
    chk("reset_soltar_sem_pulso", p, 0);
    chk("reset_soltar_estado", db_estado, 4'h0);

    // Fresh reset with buttons idle before the cycle-accurate table.
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    chk("tabela_reg_inicial", botoes_reg, 4'b0000);
    for (int i = 0; i < 15; i++) begin
      botoes = tabela[i].b;
      step();
      chk($sformatf("tabela[%0d]_jogada", i), jogada, tabela[i].jog);
      chk($sformatf("tabela[%0d]_reg", i), botoes_reg, tabela[i].breg);
      chk($sformatf("tabela[%0d]_estado", i), db_estado, tabela[i].est);
    end

    // Held press for more than 100 cycles: exactly one pulse.
    rodar(4'b0100, 107, p);
    chk("hold100_pulsos", p, 1);
    chk("hold100_reg", botoes_reg, 4'b0100);
    rodar(4'b0000, 10, p);
    chk("hold100_soltar", p, 0);

    // Bounce: 0001/0000 every 2 cycles, then stable 0001.
    p1 = 0;
    for (int k = 0; k < 5; k++) begin
      rodar(4'b0001, 2, p);
      p1 += p;
      rodar(4'b0000, 2, p);
      p1 += p;
    end
    chk("bounce_sem_pulso", p1, 0);
    rodar(4'b0001, 6, p);
    chk("bounce_estavel_antes", p, 0);
    step();
    chk("bounce_jogada", jogada, 1'b1);
    chk("bounce_reg", botoes_reg, 4'b0001);
    rodar(4'b0001, 20, p);
    chk("bounce_hold_sem_pulso", p, 0);
    rodar(4'b0000, 10, p);

    // Multi-press 0011 held 20 cycles.
    rodar(4'b0011, 2, p1);
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
    chk("multi_erro_antes", erro_multiplo, 1'b0);
`endif
    step();
    jm = jogada ? 1 : 0;
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
    chk("multi_erro_3ciclos", erro_multiplo, 1'b1);
`endif
    rodar(4'b0011, 17, p2);
    chk("multi_sem_pulso", p1 + p2 + jm, 0);
    chk("multi_reg_inalterado", botoes_reg, 4'b0001);
    chk("multi_estado", db_estado, EST_MULTI);
    rodar(4'b0000, 10, p);
    chk("multi_soltar_sem_pulso", p, 0);
    chk("multi_soltar_estado", db_estado, 4'h0);
`ifdef DETECTOR_JOGADA_MULTIPLO_EN
    chk("multi_soltar_erro", erro_multiplo, 1'b0);
`endif

    // Release bounce after an accepted 1000 press.
    rodar(4'b1000, 7, p);
    chk("solta_press_pulso", p, 1);
    chk("solta_press_reg", botoes_reg, 4'b1000);
    p1 = 0;
    rodar(4'b1000, 3, p); p1 += p;
    rodar(4'b0000, 2, p); p1 += p;
    rodar(4'b1000, 3, p); p1 += p;
    rodar(4'b0000, 3, p); p1 += p;
    rodar(4'b1000, 3, p); p1 += p;
    rodar(4'b0000, 3, p); p1 += p;
    rodar(4'b1000, 3, p); p1 += p;
    chk("solta_glitch_sem_pulso", p1, 0);
    chk("solta_glitch_estado", db_estado, 4'h3);
    rodar(4'b0000, 4, p);
    p1 = p;
    rodar(4'b0001, 6, p);
    chk("solta_prox_antes", p1 + p, 0);
    step();
    chk("solta_prox_jogada", jogada, 1'b1);
    chk("solta_prox_reg", botoes_reg, 4'b0001);
    rodar(4'b0000, 10, p);

    // Reset during the third FILTRANDO cycle.
    rodar(4'b0010, 5, p);
    chk("midreset_filtrando", db_estado, 4'h1);
    chk("midreset_antes_sem_pulso", p, 0);
    reset = 1'b0;
    step();
    chk("midreset_estado", db_estado, 4'h0);
    chk("midreset_jogada", jogada, 1'b0);
    chk("midreset_reg", botoes_reg, 4'b0000);
    reset = 1'b1;
    rodar(4'b0010, 6, p);
    chk("midreset_refiltro_sem_pulso", p, 0);
    step();
    chk("midreset_refiltro_jogada", jogada, 1'b1);
    chk("midreset_refiltro_reg", botoes_reg, 4'b0010);
    step();
    chk("midreset_pulso_unico", jogada, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
